// File: rtl/ls_functional_unit.sv
//------------------------------------------------------------------------------
// Module   : ls_functional_unit (package ls_fu_pkg in the same file)
// Purpose  : Load/store functional unit at the consumer end of the
//            reservation-station issue interface. Accepts one LDUR/STUR per
//            handshake, performs the data-memory read for loads and reports
//            completion (value, destination ROB index, fault) to the ROB.
//            Stores never touch memory here: the ROB writes memory at commit
//            using the address/data returned on the completion bus.
// Ports    : in_clk, in_rst_n              clock, async active-low reset
//            in_fu_ls_*                    issue from the RS (op, EA, data, dst)
//            in_rob_is_mispred             flush of all speculative work
//            out_fu_ls_ready               unit idle, can accept an issue
//            out_mem_req_* / in_mem_req_ready / in_mem_resp_*   memory read
//            out_rob_*                     one-cycle completion broadcast
// Options  : LS_ALIGN_CHECK_EN  when defined, LDUR/STUR with address[2:0]!=0
//                               fault at issue without a memory request.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

`ifndef GPR_SIZE
`define GPR_SIZE 63:0
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4:0
`endif

package ls_fu_pkg;
    typedef enum logic [3:0] {
        FU_OP_ADD  = 4'd0,
        FU_OP_SUB  = 4'd1,
        FU_OP_AND  = 4'd2,
        FU_OP_ORR  = 4'd3,
        FU_OP_LDUR = 4'd8,
        FU_OP_STUR = 4'd9
    } fu_op_t;
endpackage

module ls_functional_unit
    import ls_fu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   in_clk,
    input  logic                   in_rst_n,
    input  logic                   in_fu_ls_start,
    input  fu_op_t                 in_fu_ls_op,
    input  logic [`GPR_SIZE]       in_fu_ls_val_a,
    input  logic [`GPR_SIZE]       in_fu_ls_val_b,
    input  logic [`ROB_IDX_SIZE]   in_fu_ls_dst_rob_index,
    input  logic                   in_rob_is_mispred,
    output logic                   out_fu_ls_ready,
    output logic                   out_mem_req_valid,
    output logic [`GPR_SIZE]       out_mem_req_addr,
    input  logic                   in_mem_req_ready,
    input  logic                   in_mem_resp_valid,
    input  logic [`GPR_SIZE]       in_mem_resp_data,
    output logic                   out_rob_done,
    output logic [`ROB_IDX_SIZE]   out_rob_dst_rob_index,
    output logic [`GPR_SIZE]       out_rob_value,
    output logic [`GPR_SIZE]       out_rob_store_data,
    output logic                   out_rob_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Counter value on the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [`GPR_SIZE]       addr_q,  addr_d;
    logic [`ROB_IDX_SIZE]   dst_q,   dst_d;
    logic [`GPR_SIZE]       value_q, value_d;
    logic [`GPR_SIZE]       sdata_q, sdata_d;
    logic                   fault_q, fault_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   kill_q,  kill_d;

    logic w_accept;
    logic w_is_mem_op;
    logic w_misaligned;
    logic w_kill;
    logic w_done;

    assign w_accept    = in_fu_ls_start & (state_q == S_IDLE) & ~in_rob_is_mispred;
    assign w_is_mem_op = (in_fu_ls_op == FU_OP_LDUR) | (in_fu_ls_op == FU_OP_STUR);

`ifdef LS_ALIGN_CHECK_EN
    assign w_misaligned = |in_fu_ls_val_a[2:0];
`else
    assign w_misaligned = 1'b0;
`endif

    // A flush arriving in the same cycle as the response/timeout also kills.
    assign w_kill = kill_q | in_rob_is_mispred;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dst_d   = dst_q;
        value_d = value_q;
        sdata_d = sdata_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_accept) begin
                    addr_d  = in_fu_ls_val_a;
                    dst_d   = in_fu_ls_dst_rob_index;
                    value_d = '0;
                    sdata_d = '0;
                    fault_d = 1'b0;
                    if (w_is_mem_op && w_misaligned) begin
                        value_d = in_fu_ls_val_a;
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end else if (in_fu_ls_op == FU_OP_LDUR) begin
                        state_d = S_REQ;
                    end else if (in_fu_ls_op == FU_OP_STUR) begin
                        // Store completes at once; the ROB writes memory at commit.
                        value_d = in_fu_ls_val_a;
                        sdata_d = in_fu_ls_val_b;
                        state_d = S_RESP;
                    end else begin
                        fault_d = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (in_rob_is_mispred) begin
                    state_d = S_IDLE;
                end else if (in_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (in_rob_is_mispred) begin
                    kill_d = 1'b1;
                end
                // Response is checked first so it wins on the timeout cycle.
                if (in_mem_resp_valid) begin
                    value_d = in_mem_resp_data;
                    fault_d = 1'b0;
                    state_d = w_kill ? S_IDLE : S_RESP;
                end else if (cnt_q == C_CNT_LAST) begin
                    value_d = '0;
                    fault_d = 1'b1;
                    state_d = w_kill ? S_IDLE : S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_IDLE) begin
            kill_d = 1'b0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            dst_q   <= '0;
            value_q <= '0;
            sdata_q <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dst_q   <= dst_d;
            value_q <= value_d;
            sdata_q <= sdata_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
        end
    end

    // A flush during RESP suppresses the completion in that same cycle.
    assign w_done = (state_q == S_RESP) & ~in_rob_is_mispred;

    assign out_fu_ls_ready       = (state_q == S_IDLE);
    assign out_mem_req_valid     = (state_q == S_REQ);
    assign out_mem_req_addr      = (state_q == S_REQ) ? addr_q : '0;
    assign out_rob_done          = w_done;
    assign out_rob_dst_rob_index = w_done ? dst_q   : '0;
    assign out_rob_value         = w_done ? value_q : '0;
    assign out_rob_store_data    = w_done ? sdata_q : '0;
    assign out_rob_fault         = w_done & fault_q;

endmodule

`default_nettype wire

// File: doc/ls_functional_unit.md
Name: ls_functional_unit

Overview:
- Consumer end of the reservation-station to load/store issue interface.
- Accepts one issued LDUR/STUR per handshake, performs the data-memory read for loads, and reports completion (value, destination ROB index, fault) to the ROB broadcast path.
- Val_a arrives as the fully formed effective address, because base+offset is already summed before issue. Val_b is the store data.
- Stores never write memory here. The ROB performs the write at commit using the address and data returned by this block.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before a load is faulted. Range 1..255.
- CNT_W, 8: width of the wait counter. Must hold TIMEOUT_CYCLES.

Ports:
- in_clk  input  1  clock; all state changes on posedge
- in_rst_n  input  1  asynchronous active-low reset
- in_fu_ls_start  input  1  issue valid from RS
- in_fu_ls_op  input  fu_op_t  FU_OP_LDUR or FU_OP_STUR
- in_fu_ls_val_a  input  `GPR_SIZE  effective address
- in_fu_ls_val_b  input  `GPR_SIZE  store data (ignored for loads)
- in_fu_ls_dst_rob_index  input  `ROB_IDX_SIZE  destination ROB entry
- in_rob_is_mispred  input  1  flush of all speculative work
- out_fu_ls_ready  output  1  can accept an issue this cycle
- out_mem_req_valid  output  1  load read request
- out_mem_req_addr  output  `GPR_SIZE  read address
- in_mem_req_ready  input  1  memory accepts request
- in_mem_resp_valid  input  1  read data valid
- in_mem_resp_data  input  `GPR_SIZE  read data
- out_rob_done  output  1  one-cycle completion pulse
- out_rob_dst_rob_index  output  `ROB_IDX_SIZE  completed entry
- out_rob_value  output  `GPR_SIZE  load data, or store address
- out_rob_store_data  output  `GPR_SIZE  store data (0 for loads)
- out_rob_fault  output  1  completion carries a fault

Behaviour:
- Reset: asynchronous, active-low. All outputs, latches and the kill flag clear.
  - out_fu_ls_ready=1 (state IDLE); every other output 0; counter 0.
- States: IDLE, REQ, WAIT, RESP.
- Handshake:
  - Issue is accepted at a posedge where in_fu_ls_start & out_fu_ls_ready & ~in_rob_is_mispred.
  - On acceptance, op, address, data and dst index are latched.
  - out_fu_ls_ready=1 only in IDLE, so there is exactly one operation in flight.
- IDLE:
  - Accepted LDUR -> REQ.
  - Accepted STUR -> RESP with value=address, store_data=val_b, fault=0.
  - Any other op -> RESP with fault=1.
- REQ:
  - out_mem_req_valid=1 and addr held stable until in_mem_req_ready.
  - On ready -> WAIT with counter=0.
- WAIT:
  - Counter increments each cycle.
  - in_mem_resp_valid -> data latched, then RESP.
  - Counter reaching TIMEOUT_CYCLES without response -> RESP with fault=1, value=0.
  - A response arriving on the timeout cycle wins; no fault.
- RESP:
  - out_rob_done=1 for exactly this cycle, with index/value/store_data/fault valid; then -> IDLE.
  - Done is registered, so the minimum load latency is issue edge + 3 edges with zero memory wait. A store completes 1 edge after issue.
- Mispred (sampled at posedge), by state:
  - IDLE: any simultaneous start is dropped.
  - REQ: request is abandoned -> IDLE next edge.
  - WAIT: kill flag set. The response, or timeout, is still drained, then -> IDLE with no done.
  - RESP: done is suppressed, -> IDLE.
  - Kill flag clears on entering IDLE.
- Reset mid-operation: immediately returns to IDLE. Any later stray in_mem_resp_valid is ignored in IDLE/REQ.
- Outputs outside RESP: out_rob_* hold 0.

Optional Feature:
- LS_ALIGN_CHECK_EN
  - Defined: in IDLE, an accepted LDUR/STUR with address[2:0]!=0 goes directly to RESP with fault=1 and value=address. No memory request is made.
  - Undefined: no alignment check; the address is passed unmodified.

Test Plan:
- Load, zero wait: issue LDUR addr=0x100 dst=5; req_ready immediately; resp 0xDEAD one cycle later -> single done pulse, dst=5, value=0xDEAD, fault=0; ready low throughout.
- Store: issue STUR addr=0x40 data=77 dst=2 -> done next edge, value=0x40, store_data=77, no mem_req_valid.
- Backpressure: req_ready held low 4 cycles -> req_valid and addr=0x200 stable 4 cycles, then completes normally.
- Timeout: TIMEOUT_CYCLES=3, no response -> done with fault=1, value=0; ready returns 1 next cycle.
- Flush: mispred during WAIT, resp arrives 2 cycles later -> no done; next issue accepted after IDLE. Also, mispred asserted together with start -> start not accepted.
- Align (macro on): LDUR addr=0x103 -> fault=1, value=0x103, req_valid never asserted. Macro off -> normal request to 0x103.
